// File: rtl/wb_pipe_checker_if.sv
// Pipelined Wishbone B4 link signals, with a passive monitor view for checkers.
interface wb_pipe_checker_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat_m;
    logic          stall;
    logic          ack;
    logic          err;

    modport master (output cyc, stb, we, adr, sel, dat_m, input stall, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_m, output stall, ack, err);
    modport monitor(input cyc, stb, we, adr, sel, dat_m, stall, ack, err);
endinterface

// File: rtl/wb_pipe_checker.sv
// Passive pipelined Wishbone protocol checker: outstanding tracking, timeouts,
// spurious/double responses, stall stability and abort detection with sticky flags.
module wb_pipe_checker #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int SW              = DW / 8,
    parameter int MAXWAITS        = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ALLOW_ABORT     = 0,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int WW             = $clog2(MAXWAITS + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    wb_pipe_checker_if.monitor     bus,
    output logic [OW-1:0]          outstanding,
    output logic [31:0]            txn_cnt,
    output logic [5:0]             err_flags,
    output logic                   err_irq,
    output logic [3:0]             first_err
);
    localparam logic [OW-1:0] OMAX     = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAITS);
    localparam logic [WW-1:0] WAIT_TC  = WW'(MAXWAITS - 1);

    logic          accept;
    logic          resp;
    logic          silent;
    logic [5:0]    det;
    logic [2:0]    det_low;
    logic [WW-1:0] wait_cnt;

    logic          cyc_q;
    logic          stalled_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] dat_q;

    always_comb begin
        accept = bus.cyc & bus.stb & ~bus.stall;
        resp   = bus.cyc & (bus.ack | bus.err);
        silent = (outstanding != '0) & ~resp;

        det    = '0;
        det[0] = resp & (outstanding == '0);
        det[1] = silent & (wait_cnt == WAIT_TC);
        det[2] = accept & ~resp & (outstanding == OMAX);
        // A stalled request must be presented unchanged until it is accepted.
        det[3] = stalled_q & (~bus.cyc | ~bus.stb | (bus.adr != adr_q) | (bus.we != we_q) |
                              (bus.sel != sel_q) | (we_q & (bus.dat_m != dat_q)));
        det[4] = (ALLOW_ABORT == 0) & cyc_q & ~bus.cyc & (outstanding != '0);
        det[5] = bus.cyc & bus.ack & bus.err;

        det_low = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (det[i]) det_low = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            wait_cnt    <= '0;
            cyc_q       <= 1'b0;
            stalled_q   <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
        end else begin
            cyc_q     <= bus.cyc;
            stalled_q <= bus.cyc & bus.stb & bus.stall;
            we_q      <= bus.we;
            adr_q     <= bus.adr;
            sel_q     <= bus.sel;
            dat_q     <= bus.dat_m;

            if (!bus.cyc) begin
                outstanding <= '0;
            end else if (accept & ~resp) begin
                if (outstanding != OMAX) outstanding <= outstanding + OW'(1);
            end else if (resp & ~accept) begin
                if (outstanding != '0) outstanding <= outstanding - OW'(1);
            end

            if (resp | (outstanding == '0)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_cnt   <= '0;
            err_flags <= '0;
            first_err <= '0;
        end else if (clear) begin
            txn_cnt   <= '0;
            err_flags <= '0;
            first_err <= '0;
        end else begin
            if (resp & (outstanding != '0) & (txn_cnt != 32'hFFFF_FFFF)) txn_cnt <= txn_cnt + 32'd1;
            err_flags <= err_flags | det;
            if (!first_err[3] && (det != '0)) first_err <= {1'b1, det_low};
        end
    end

    assign err_irq = |err_flags;
endmodule

// File: tb/tb_wb_pipe_checker.sv
// Scoreboard bench for wb_pipe_checker: one shared bus, two checkers differing in ALLOW_ABORT.
module tb_wb_pipe_checker;
    localparam int MAXW = 16;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    wb_pipe_checker_if #(.AW(32), .DW(32), .SW(4)) bus ();

    logic [2:0]  out_v [2];
    logic [31:0] txn_v [2];
    logic [5:0]  flg_v [2];
    logic        irq_v [2];
    logic [3:0]  fe_v  [2];

    wb_pipe_checker #(.AW(32), .DW(32), .SW(4), .MAXWAITS(MAXW), .MAX_OUTSTANDING(MAXO),
                      .ALLOW_ABORT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
        .outstanding(out_v[0]), .txn_cnt(txn_v[0]), .err_flags(flg_v[0]),
        .err_irq(irq_v[0]), .first_err(fe_v[0]));

    wb_pipe_checker #(.AW(32), .DW(32), .SW(4), .MAXWAITS(MAXW), .MAX_OUTSTANDING(MAXO),
                      .ALLOW_ABORT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
        .outstanding(out_v[1]), .txn_cnt(txn_v[1]), .err_flags(flg_v[1]),
        .err_irq(irq_v[1]), .first_err(fe_v[1]));

    typedef struct {
        int          cnt;
        logic [31:0] txn;
        logic [5:0]  flags [2];
        logic [3:0]  fe    [2];
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int failed = 0;

    // Reference model state, described in terms of the protocol rules.
    int          m_cnt;
    int          m_wait;
    logic [31:0] m_txn;
    logic [5:0]  m_flags [2];
    logic [3:0]  m_fe    [2];
    logic        m_prev_cyc, m_stalled, m_we_c;
    logic [31:0] m_adr_c, m_dat_c;
    logic [3:0]  m_sel_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wait = 0; m_txn = '0;
        m_prev_cyc = 0; m_stalled = 0; m_we_c = 0;
        m_adr_c = '0; m_dat_c = '0; m_sel_c = '0;
        for (int i = 0; i < 2; i++) begin m_flags[i] = '0; m_fe[i] = '0; end
    endtask

    task automatic model_step(input logic c, s, w, input logic [31:0] a, input logic [3:0] sl,
                              input logic [31:0] d, input logic st, ak, er, cl);
        logic acc, rsp, abrt;
        logic [5:0] det, di;
        int low;
        exp_t e;
        acc  = c && s && !st;
        rsp  = c && (ak || er);
        det  = '0;
        det[0] = rsp && (m_cnt == 0);
        det[1] = (m_cnt > 0) && !rsp && (m_wait + 1 == MAXW);
        det[2] = acc && !rsp && (m_cnt == MAXO);
        det[3] = m_stalled && (!c || !s || a != m_adr_c || w != m_we_c || sl != m_sel_c ||
                               (m_we_c && d != m_dat_c));
        det[5] = c && ak && er;
        abrt   = m_prev_cyc && !c && (m_cnt > 0);
        for (int i = 0; i < 2; i++) begin
            di = det;
            di[4] = abrt && (i == 0);
            if (cl) begin
                m_flags[i] = '0; m_fe[i] = '0;
            end else begin
                m_flags[i] = m_flags[i] | di;
                if (!m_fe[i][3] && di != 0) begin
                    low = 0;
                    for (int b = 5; b >= 0; b--) if (di[b]) low = b;
                    m_fe[i] = 4'(8 + low);
                end
            end
        end
        if (cl) m_txn = '0;
        else if (rsp && m_cnt > 0 && m_txn != 32'hFFFF_FFFF) m_txn = m_txn + 1;
        if (rsp || m_cnt == 0) m_wait = 0;
        else if (m_wait < MAXW) m_wait = m_wait + 1;
        if (!c) m_cnt = 0;
        else begin
            m_cnt = m_cnt + ((acc && !rsp) ? 1 : 0) - ((rsp && !acc) ? 1 : 0);
            if (m_cnt > MAXO) m_cnt = MAXO;
            if (m_cnt < 0) m_cnt = 0;
        end
        m_stalled = c && s && st;
        m_adr_c = a; m_we_c = w; m_sel_c = sl; m_dat_c = d;
        m_prev_cyc = c;
        e.cnt = m_cnt; e.txn = m_txn;
        for (int i = 0; i < 2; i++) begin e.flags[i] = m_flags[i]; e.fe[i] = m_fe[i]; end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic c, s, w, input logic [31:0] a, input logic [3:0] sl,
                        input logic [31:0] d, input logic st, ak, er, cl);
        @(negedge clk);
        bus.cyc = c; bus.stb = s; bus.we = w; bus.adr = a; bus.sel = sl; bus.dat_m = d;
        bus.stall = st; bus.ack = ak; bus.err = er; clear = cl;
        model_step(c, s, w, a, sl, d, st, ak, er, cl);
    endtask

    task automatic idle(input int n, input logic cl);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, cl);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_outstanding"}, 32'(out_v[i]), 32'h0);
            chk({tag, "_txn_cnt"}, txn_v[i], 32'h0);
            chk({tag, "_err_flags"}, 32'(flg_v[i]), 32'h0);
            chk({tag, "_err_irq"}, 32'(irq_v[i]), 32'h0);
            chk({tag, "_first_err"}, 32'(fe_v[i]), 32'h0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++; failed++;
            $display("FAIL %s_queue: got %0d pending expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        reset_n = 1'b0;
        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0; bus.dat_m = '0;
        bus.stall = 0; bus.ack = 0; bus.err = 0; clear = 0;
        model_reset();
        #1 check_zero(tag);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every clock the DUTs present a new state; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("outstanding[%0d]", i), 32'(out_v[i]), 32'(e.cnt));
                    chk($sformatf("txn_cnt[%0d]", i), txn_v[i], e.txn);
                    chk($sformatf("err_flags[%0d]", i), 32'(flg_v[i]), 32'(e.flags[i]));
                    chk($sformatf("err_irq[%0d]", i), 32'(irq_v[i]), 32'(|e.flags[i]));
                    chk($sformatf("first_err[%0d]", i), 32'(fe_v[i]), 32'(e.fe[i]));
                end
            end
        end
    end

    initial begin
        logic c, s, w, st, ak, er, cl;
        logic [31:0] a, d;
        logic [3:0] sl;
        int n;

        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0; bus.dat_m = '0;
        bus.stall = 0; bus.ack = 0; bus.err = 0;
        model_reset();
        #3 check_zero("power_on");
        @(negedge clk);
        reset_n = 1'b1;

        // Single read, ACK three cycles after accept.
        step(1, 1, 0, 32'h10, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h10, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h10, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h10, 4'hF, 32'h0, 0, 1, 0, 0);
        idle(2, 0);

        // Four writes fill the pipe, a fifth accept overflows, then four ACKs drain it.
        for (int k = 0; k < 5; k++) step(1, 1, 1, 32'h200 + 32'(k * 4), 4'hF, 32'hA000 + 32'(k), 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        idle(1, 1);

        // Timeout after MAXW silent cycles, then a late ACK.
        step(1, 1, 0, 32'h40, 4'hF, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < MAXW + 3; k++) step(1, 0, 0, 32'h40, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h40, 4'hF, 32'h0, 0, 1, 0, 0);
        idle(1, 1);

        // Address changes while stalled.
        step(1, 1, 1, 32'h100, 4'hF, 32'h55, 1, 0, 0, 0);
        step(1, 1, 1, 32'h104, 4'hF, 32'h55, 1, 0, 0, 0);
        step(1, 1, 1, 32'h104, 4'hF, 32'h55, 1, 0, 0, 0);
        step(1, 1, 1, 32'h104, 4'hF, 32'h55, 0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);
        idle(1, 1);
        // Read with data bus wandering while stalled is legal.
        step(1, 1, 0, 32'h100, 4'hF, 32'h1, 1, 0, 0, 0);
        step(1, 1, 0, 32'h100, 4'hF, 32'h2, 1, 0, 0, 0);
        step(1, 1, 0, 32'h100, 4'hF, 32'h3, 1, 0, 0, 0);
        step(1, 1, 0, 32'h100, 4'hF, 32'h4, 0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);
        idle(1, 0);

        // Spurious ACK, then ACK and ERR together on a real response, then clear.
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);
        step(1, 1, 0, 32'h8, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 1);
        idle(1, 0);

        // Two outstanding, then CYC dropped.
        step(1, 1, 0, 32'h20, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h24, 4'hF, 32'h0, 0, 0, 0, 0);
        idle(2, 0);
        idle(1, 1);

        // Reset in the middle of a transaction, then a fresh transaction.
        step(1, 1, 1, 32'h30, 4'hF, 32'h9, 0, 0, 0, 0);
        step(1, 1, 1, 32'h34, 4'hF, 32'h9, 1, 0, 0, 0);
        do_reset("mid_reset");
        step(1, 1, 0, 32'h30, 4'hF, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            c  = ($urandom_range(0, 19) != 0);
            s  = $urandom_range(0, 1);
            w  = $urandom_range(0, 1);
            st = ($urandom_range(0, 3) == 0);
            a  = 32'($urandom_range(0, 3) * 4);
            sl = 4'($urandom_range(0, 15));
            d  = $urandom;
            ak = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
            er = ($urandom_range(0, 25) == 0);
            cl = ($urandom_range(0, 60) == 0);
            step(c, s, w, a, sl, d, st, ak, er, cl);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
